// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Byte-stream loader that sits in front of the instruction register. A host
// (typically a UART) delivers a framed byte stream over a valid/ready
// handshake:
//
//   HDR, CNT, {HI, LO} x CNT
//
//   HDR[7]   : target memory (1 = instruction, 0 = data)
//   HDR[6:5] : reserved, must be 2'b00
//   HDR[4:0] : start address
//   CNT      : number of 16-bit words, 1..32
//
// Each assembled word is written through the instruction register's unified
// write port with a single-cycle load strobe. The CPU is held off via
// cpu_hold for as long as a frame is in progress. A malformed header, an
// out-of-range count or a stalled stream aborts the frame with an error pulse.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   in_valid        in_byte holds a valid byte
//   in_byte[7:0]    stream byte
//   in_ready        loader accepts in_byte this cycle
//   load            one-cycle write strobe to the instruction register
//   is_instruction  write target (1 = instruction memory, 0 = data memory)
//   load_address    write address
//   cpu_input       write data {hi_byte, lo_byte}
//   cpu_hold        high while a frame is being processed
//   done            one-cycle pulse, frame fully written
//   error           one-cycle pulse, frame aborted
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  load,
    output logic                  is_instruction,
    output logic [ADDR_WIDTH-1:0] load_address,
    output logic [15:0]           cpu_input,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW    = $clog2(DEPTH + 1);

    localparam logic [7:0]    MAX_CNT  = 8'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CNT   = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [RW-1:0] remaining;
    logic [7:0]    hi_byte;
    logic [TW-1:0] tmo_cnt;
    logic          xfer;
    logic          tmo_hit;
    logic          waiting;

    // in_ready is itself a register, so this never loops back from in_valid
    // into an output.
    assign xfer    = in_valid && in_ready;
    // Expiry is taken on the edge where the idle counter would reach the limit.
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign waiting = (state == S_CNT) || (state == S_HI) || (state == S_LO);

    // NOTE: next_state is assigned a default before the case statement so that
    // every path through this block drives it; otherwise a latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (xfer) next_state = (in_byte[6:5] != 2'b00) ? S_ERR : S_CNT;
            end
            S_CNT: begin
                if (xfer)
                    next_state = (in_byte == 8'd0 || in_byte > MAX_CNT) ? S_ERR : S_HI;
                else if (tmo_hit)
                    next_state = S_ERR;
            end
            S_HI: begin
                if (xfer)         next_state = S_LO;
                else if (tmo_hit) next_state = S_ERR;
            end
            S_LO: begin
                // A timeout here aborts before WRITE, so no partial word is stored.
                if (xfer)         next_state = S_WRITE;
                else if (tmo_hit) next_state = S_ERR;
            end
            S_WRITE: next_state = (remaining == RW'(1)) ? S_DONE : S_HI;
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            in_ready       <= 1'b0;
            load           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_hold       <= 1'b0;
            is_instruction <= 1'b0;
            load_address   <= '0;
            cpu_input      <= '0;
            remaining      <= '0;
            hi_byte        <= '0;
            tmo_cnt        <= '0;
        end else begin
            state <= next_state;

            // Strobes and handshake are decoded from the upcoming state so they
            // are registered yet line up exactly with the state they describe.
            in_ready <= (next_state == S_IDLE) || (next_state == S_CNT) ||
                        (next_state == S_HI)   || (next_state == S_LO);
            load     <= (next_state == S_WRITE);
            done     <= (next_state == S_DONE);
            error    <= (next_state == S_ERR);
            cpu_hold <= (next_state != S_IDLE);

            if (waiting && !xfer) tmo_cnt <= tmo_cnt + TW'(1);
            else                  tmo_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (xfer && next_state == S_CNT) begin
                        is_instruction <= in_byte[7];
                        load_address   <= in_byte[ADDR_WIDTH-1:0];
                    end
                end
                S_CNT: begin
                    if (xfer) remaining <= in_byte[RW-1:0];
                end
                S_HI: begin
                    if (xfer) hi_byte <= in_byte;
                end
                S_LO: begin
                    if (xfer) cpu_input <= {hi_byte, in_byte};
                end
                S_WRITE: begin
                    // load_address is the live write pointer; it advances after
                    // the strobe and wraps naturally at the memory depth.
                    load_address <= load_address + ADDR_WIDTH'(1);
                    remaining    <= remaining - RW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Scoreboard bench for program_loader. Stimulus tasks build frames, predict
// the resulting write/done/error events from the frame rules and queue them;
// an independent monitor pops and compares every event the DUT produces.
// -----------------------------------------------------------------------------
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        load;
    logic        is_instruction;
    logic [4:0]  load_address;
    logic [15:0] cpu_input;
    logic        cpu_hold;
    logic        done;
    logic        error;

    program_loader #(.ADDR_WIDTH(5), .TIMEOUT_CYCLES(255)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .in_ready       (in_ready),
        .load           (load),
        .is_instruction (is_instruction),
        .load_address   (load_address),
        .cpu_input      (cpu_input),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef enum logic [1:0] {EV_LOAD, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [4:0]  addr;
        logic [15:0] data;
        logic        instr;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] frame_words[$];
    int          last_xfer_cyc = -100;
    int          exp_loads     = 0;
    int          loads_seen    = 0;

    // ---------------- monitor ----------------
    initial begin : monitor
        ev_t      e;
        ev_kind_t kind;
        bit       prev_end;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_end = 1'b0;
            end else begin
                if (prev_end) check("hold_after_end", cpu_hold, 0);
                prev_end = done || error;
                if (load || done || error) begin
                    kind = load ? EV_LOAD : (done ? EV_DONE : EV_ERR);
                    check("one_strobe", 32'(int'(load) + int'(done) + int'(error)), 1);
                    check("hold_in_frame", cpu_hold, 1);
                    check("ready_low", in_ready, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event: got kind %0d expected none", kind);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", kind, e.kind);
                        if (kind == EV_LOAD) begin
                            loads_seen++;
                            check("load_addr",  load_address, e.addr);
                            check("load_data",  cpu_input, e.data);
                            check("load_instr", is_instruction, e.instr);
                            check("load_latency", cyc, last_xfer_cyc + 1);
                        end else if (kind == EV_DONE) begin
                            check("done_latency", cyc, last_xfer_cyc + 2);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 3);
        @(negedge clk);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 400; i++) begin
            if (in_ready) begin
                last_xfer_cyc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL byte_accept: got no in_ready in 400 cycles expected acceptance of 0x%0h", b);
        in_valid = 1'b0;
    endtask

    task automatic push_ev(input ev_kind_t k, input int addr, input logic [15:0] data, input logic instr);
        ev_t e;
        e.kind  = k;
        e.addr  = 5'(addr);
        e.data  = data;
        e.instr = instr;
        exp_q.push_back(e);
        if (k == EV_LOAD) exp_loads++;
    endtask

    // Predict the events a frame must produce, then stream it.
    task automatic run_frame(input logic [7:0] hdr, input logic [7:0] cnt);
        if (hdr[6:5] != 2'b00) begin
            push_ev(EV_ERR, 0, 16'h0, 1'b0);
            send_byte(hdr);
        end else if (cnt == 0 || cnt > 32) begin
            push_ev(EV_ERR, 0, 16'h0, 1'b0);
            send_byte(hdr);
            send_byte(cnt);
        end else begin
            for (int i = 0; i < int'(cnt); i++)
                push_ev(EV_LOAD, (int'(hdr[4:0]) + i) % 32, frame_words[i], hdr[7]);
            push_ev(EV_DONE, 0, 16'h0, 1'b0);
            send_byte(hdr);
            send_byte(cnt);
            for (int i = 0; i < int'(cnt); i++) begin
                send_byte(frame_words[i][15:8]);
                send_byte(frame_words[i][7:0]);
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_load"},     load, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_error"},    error, 0);
        check({tag, "_hold"},     cpu_hold, 0);
        check({tag, "_addr"},     load_address, 0);
        check({tag, "_data"},     cpu_input, 0);
        check({tag, "_instr"},    is_instruction, 0);
    endtask

    task automatic set_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] hdr;
        logic [7:0] cnt;

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two instruction words at address 0.
        frame_words = '{16'h1234, 16'hABCD};
        run_frame(8'h80, 8'h02);
        drain("drain_basic", 100);

        // Single data word at address 5.
        frame_words = '{16'h000A};
        run_frame(8'h05, 8'h01);
        drain("drain_single", 100);

        // Address wrap 30, 31, 0, 1.
        set_words(4);
        run_frame(8'h9E, 8'h04);
        drain("drain_wrap", 100);

        // Malformed header and out-of-range counts.
        run_frame(8'hA0, 8'h00);
        drain("drain_bad_hdr", 100);
        run_frame(8'h03, 8'h00);
        drain("drain_cnt0", 100);
        run_frame(8'h03, 8'h21);
        drain("drain_cnt33", 100);

        // Full-depth frame.
        set_words(32);
        run_frame(8'h91, 8'd32);
        drain("drain_full", 200);

        // Stall after a hi byte: timeout abort, then a clean frame.
        push_ev(EV_ERR, 0, 16'h0, 1'b0);
        send_byte(8'h83);
        send_byte(8'h02);
        send_byte(8'h55);
        drain("drain_timeout", 600);
        check("hold_after_timeout", cpu_hold, 0);
        set_words(2);
        run_frame(8'h8C, 8'h02);
        drain("drain_after_timeout", 100);

        // Reset while waiting for the lo byte of word 2.
        set_words(2);
        push_ev(EV_LOAD, 7, frame_words[0], 1'b1);
        send_byte(8'h87);
        send_byte(8'h02);
        send_byte(frame_words[0][15:8]);
        send_byte(frame_words[0][7:0]);
        send_byte(frame_words[1][15:8]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drain("drain_reset", 50);

        // Randomized frames, some malformed.
        for (int f = 0; f < 25; f++) begin
            hdr = 8'($urandom);
            if ($urandom_range(0, 9) != 0) hdr[6:5] = 2'b00;
            cnt = 8'($urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) cnt = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(33, 255));
            set_words(int'(cnt));
            run_frame(hdr, cnt);
            drain("drain_random", 200);
        end

        check("total_loads", loads_seen, exp_loads);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
